// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared definitions for the MULDIV issue controller:
//                EX-stage HI/LO opcode classes, MULDIV op encodings, FSM
//                state encoding and the opcode-to-MULDIV-op mapping helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    // HI/LO instruction class carried in the ID/EX register (4 bits).
    // Codes 9..15 are unused and behave like MD_NONE.
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    // MULDIV op port encoding.
    localparam logic [1:0] MDOP_MULTU = 2'd0;
    localparam logic [1:0] MDOP_MULT  = 2'd1;
    localparam logic [1:0] MDOP_DIVU  = 2'd2;
    localparam logic [1:0] MDOP_DIV   = 2'd3;

    // Controller FSM encoding.
    typedef logic [1:0] md_state_t;
    localparam md_state_t ST_IDLE   = 2'd0;
    localparam md_state_t ST_ISSUED = 2'd1;
    localparam md_state_t ST_WAIT   = 2'd2;

    // Arithmetic class to MULDIV op; non-arithmetic classes map to 0.
    function automatic logic [1:0] md_op_map(input logic [3:0] op);
        logic [1:0] r;
        r = MDOP_MULTU;
        case (op)
            MD_MULT:  r = MDOP_MULT;
            MD_MULTU: r = MDOP_MULTU;
            MD_DIV:   r = MDOP_DIV;
            MD_DIVU:  r = MDOP_DIVU;
            default:  r = MDOP_MULTU;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : md_issue_ctrl
//  Description : EX-stage controller in front of MULDIV. Decodes the HI/LO
//                instruction class, issues start/we to MULDIV, tracks the
//                in-flight operation (including the one-cycle gap between
//                Start and Busy rising), stalls IF/ID/EX while a HI/LO
//                instruction must wait, and returns HI/LO for mfhi/mflo.
//  Revision    : 1.0 - initial release
//
//  Optional feature (compile-time macro MD_WDOG_EN):
//    defined   - WAIT watchdog; after WDOG_LIMIT WAIT cycles the controller
//                sets the sticky md_timeout flag and returns to IDLE.
//    undefined - no watchdog, md_timeout tied low.
//
//  Parameters:
//    WDOG_LIMIT   : WAIT cycles tolerated before timeout (MD_WDOG_EN only)
//
//  Ports:
//    clk, reset       : clock, synchronous active-high reset
//    ex_valid         : EX stage holds a valid instruction
//    ex_md_op [3:0]   : HI/LO instruction class
//    ex_rs_val[31:0]  : forwarded rs operand
//    ex_rt_val[31:0]  : forwarded rt operand
//    flush            : EX instruction squashed this cycle
//    md_busy          : MULDIV Busy
//    md_hi/md_lo      : MULDIV HI / LO
//    md_start         : MULDIV Start
//    md_op [1:0]      : MULDIV op (0 MULTU, 1 MULT, 2 DIVU, 3 DIV)
//    md_we, md_hilo   : MULDIV HI/LO write enable and select (1 = HI)
//    md_d1, md_d2     : MULDIV operands (rs, rt)
//    md_stall         : freeze IF/ID/EX
//    ex_md_result     : HI for mfhi, LO for mflo, else 0
//    md_timeout       : sticky watchdog flag
// ============================================================================
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int WDOG_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [3:0]  ex_md_op,
    input  logic [31:0] ex_rs_val,
    input  logic [31:0] ex_rt_val,
    input  logic        flush,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        md_start,
    output logic [1:0]  md_op,
    output logic        md_we,
    output logic        md_hilo,
    output logic [31:0] md_d1,
    output logic [31:0] md_d2,
    output logic        md_stall,
    output logic [31:0] ex_md_result,
    output logic        md_timeout
);

    md_state_t r_state;
    md_state_t w_state_nxt;

    logic w_op_known;
    logic w_hit;
    logic w_arith;
    logic w_move;
    logic w_idle;
    logic w_wdog_expire;

    assign w_op_known = (ex_md_op >= MD_MULT) && (ex_md_op <= MD_MTLO);
    assign w_hit      = ex_valid && !flush && w_op_known;
    assign w_arith    = w_hit && (ex_md_op <= MD_DIVU);
    assign w_move     = w_hit && ((ex_md_op == MD_MTHI) || (ex_md_op == MD_MTLO));
    // IDLE is the only state in which HI/LO are final and MULDIV is free,
    // so every new start or direct write is confined to it.
    assign w_idle     = (r_state == ST_IDLE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef MD_WDOG_EN
    localparam logic [7:0] c_wdog_limit = 8'(WDOG_LIMIT);

    logic [7:0] r_wdog_cnt;
    logic       r_timeout;

    // The counter sits at zero outside WAIT, so it is cleared on entry and
    // counts completed WAIT cycles; expiry is judged on the cycle that would
    // bring it to the limit.
    assign w_wdog_expire = (r_state == ST_WAIT) && md_busy &&
                           ((r_wdog_cnt + 8'd1) == c_wdog_limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            if (r_state == ST_WAIT) begin
                r_wdog_cnt <= r_wdog_cnt + 8'd1;
            end else begin
                r_wdog_cnt <= 8'd0;
            end
            if (w_wdog_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign md_timeout = r_timeout;
`else
    assign w_wdog_expire = 1'b0;
    assign md_timeout    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (md_start) begin
                    w_state_nxt = ST_ISSUED;
                end
            end
            // Busy is not yet visible in the cycle after Start; ISSUED covers
            // that gap. If Busy is still low here the unit either finished
            // instantly or never responded, so return to IDLE.
            ST_ISSUED: begin
                w_state_nxt = md_busy ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                if (!md_busy || w_wdog_expire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        md_start     = 1'b0;
        md_op        = MDOP_MULTU;
        md_we        = 1'b0;
        md_hilo      = 1'b0;
        md_stall     = 1'b0;
        ex_md_result = 32'd0;
        if (!reset) begin
            md_start = w_arith && w_idle;
            md_op    = md_op_map(ex_md_op);
            md_we    = w_move && w_idle;
            md_hilo  = (ex_md_op == MD_MTHI);
            // Any HI/LO instruction waits while an op is outstanding; a
            // squashed one is gone and must not hold the pipeline.
            md_stall = w_hit && !w_idle;
            case (ex_md_op)
                MD_MFHI: ex_md_result = md_hi;
                MD_MFLO: ex_md_result = md_lo;
                default: ex_md_result = 32'd0;
            endcase
        end
    end

    assign md_d1 = ex_rs_val;
    assign md_d2 = ex_rt_val;

endmodule
`default_nettype wire

// File: tb/tb_md_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_issue_ctrl
//  Description : Self-checking bench for md_issue_ctrl. MULDIV is modelled by
//                the bench driving md_busy/md_hi/md_lo directly. Each table
//                row is one clock cycle of inputs plus the expected outputs.
//                With MD_WDOG_EN a second instance (WDOG_LIMIT=4) shares the
//                inputs and exercises the watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md_issue_ctrl;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic [3:0]  ex_md_op;
    logic [31:0] ex_rs_val;
    logic [31:0] ex_rt_val;
    logic        flush;
    logic        md_busy;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic        md_start;
    logic [1:0]  md_op;
    logic        md_we;
    logic        md_hilo;
    logic [31:0] md_d1;
    logic [31:0] md_d2;
    logic        md_stall;
    logic [31:0] ex_md_result;
    logic        md_timeout;

    int checks = 0;
    int errors = 0;

    md_issue_ctrl #(.WDOG_LIMIT(16)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_md_op(ex_md_op),
        .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .flush(flush),
        .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo),
        .md_start(md_start), .md_op(md_op), .md_we(md_we), .md_hilo(md_hilo),
        .md_d1(md_d1), .md_d2(md_d2), .md_stall(md_stall),
        .ex_md_result(ex_md_result), .md_timeout(md_timeout)
    );

`ifdef MD_WDOG_EN
    logic        wd_start;
    logic [1:0]  wd_op;
    logic        wd_we;
    logic        wd_hilo;
    logic [31:0] wd_d1;
    logic [31:0] wd_d2;
    logic        wd_stall;
    logic [31:0] wd_result;
    logic        wd_timeout;

    md_issue_ctrl #(.WDOG_LIMIT(4)) dut_wd (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_md_op(ex_md_op),
        .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .flush(flush),
        .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo),
        .md_start(wd_start), .md_op(wd_op), .md_we(wd_we), .md_hilo(wd_hilo),
        .md_d1(wd_d1), .md_d2(wd_d2), .md_stall(wd_stall),
        .ex_md_result(wd_result), .md_timeout(wd_timeout)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        fl;
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        e_start;
        logic [1:0]  e_op;
        logic        e_we;
        logic        e_hilo;
        logic        e_stall;
        logic [31:0] e_res;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic v, input logic [3:0] op,
        input logic [31:0] rs, input logic [31:0] rt, input logic fl,
        input logic busy, input logic [31:0] hi, input logic [31:0] lo,
        input logic es, input logic [1:0] eo, input logic ew,
        input logic eh, input logic est, input logic [31:0] er);
        vec_t t;
        t.rst = rst; t.v = v; t.op = op; t.rs = rs; t.rt = rt; t.fl = fl;
        t.busy = busy; t.hi = hi; t.lo = lo;
        t.e_start = es; t.e_op = eo; t.e_we = ew; t.e_hilo = eh;
        t.e_stall = est; t.e_res = er;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read 1 time unit later,
    // well away from the rising edge that advances the FSM.
    task automatic drive(input vec_t t);
        @(negedge clk);
        reset     = t.rst;
        ex_valid  = t.v;
        ex_md_op  = t.op;
        ex_rs_val = t.rs;
        ex_rt_val = t.rt;
        flush     = t.fl;
        md_busy   = t.busy;
        md_hi     = t.hi;
        md_lo     = t.lo;
        #1;
    endtask

    task automatic apply(input vec_t t, input string tag);
        drive(t);
        chk({tag, ".start"},   {31'd0, md_start},   {31'd0, t.e_start});
        chk({tag, ".op"},      {30'd0, md_op},      {30'd0, t.e_op});
        chk({tag, ".we"},      {31'd0, md_we},      {31'd0, t.e_we});
        chk({tag, ".hilo"},    {31'd0, md_hilo},    {31'd0, t.e_hilo});
        chk({tag, ".stall"},   {31'd0, md_stall},   {31'd0, t.e_stall});
        chk({tag, ".result"},  ex_md_result,        t.e_res);
        chk({tag, ".d1"},      md_d1,               t.rs);
        chk({tag, ".d2"},      md_d2,               t.rt);
        chk({tag, ".timeout"}, {31'd0, md_timeout}, 32'd0);
    endtask

    vec_t tbl[$];

    initial begin
        #100000;
        $display("FAIL sim_timeout: bench did not reach its summary");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        reset = 1'b1; ex_valid = 1'b0; ex_md_op = 4'd0; ex_rs_val = 32'd0;
        ex_rt_val = 32'd0; flush = 1'b0; md_busy = 1'b0; md_hi = 32'd0; md_lo = 32'd0;

        //           rst v op  rs            rt     fl bsy hi            lo            st op we hl stl result
        // reset and quiet idle
        tbl.push_back(mk(1,0,0, 0,            0,     0,0, 0,            0,            0,0,0,0,0, 0));
        tbl.push_back(mk(0,0,0, 0,            0,     0,0, 0,            0,            0,0,0,0,0, 0));
        // MULTU 3*5, MFLO stalls through ISSUED + 5 busy-tracking cycles
        tbl.push_back(mk(0,1,2, 3,            5,     0,0, 0,            0,            1,0,0,0,0, 0));
        tbl.push_back(mk(0,1,6, 0,            0,     0,1, 0,            0,            0,0,0,0,1, 0));
        tbl.push_back(mk(0,1,6, 0,            0,     0,1, 0,            0,            0,0,0,0,1, 0));
        tbl.push_back(mk(0,1,6, 0,            0,     0,1, 0,            0,            0,0,0,0,1, 0));
        tbl.push_back(mk(0,1,6, 0,            0,     0,1, 0,            0,            0,0,0,0,1, 0));
        tbl.push_back(mk(0,1,6, 0,            0,     0,1, 0,            0,            0,0,0,0,1, 0));
        tbl.push_back(mk(0,1,6, 0,            0,     0,0, 0,            15,           0,0,0,0,1, 15));
        tbl.push_back(mk(0,1,6, 0,            0,     0,0, 0,            15,           0,0,0,0,0, 15));
        // DIV 7/2 then MFHI back-to-back; MFHI=1, MFLO=3
        tbl.push_back(mk(0,1,3, 7,            2,     0,0, 0,            15,           1,3,0,0,0, 0));
        tbl.push_back(mk(0,1,5, 0,            0,     0,1, 0,            15,           0,0,0,0,1, 0));
        tbl.push_back(mk(0,1,5, 0,            0,     0,1, 0,            15,           0,0,0,0,1, 0));
        tbl.push_back(mk(0,1,5, 0,            0,     0,1, 0,            15,           0,0,0,0,1, 0));
        tbl.push_back(mk(0,1,5, 0,            0,     0,1, 0,            15,           0,0,0,0,1, 0));
        tbl.push_back(mk(0,1,5, 0,            0,     0,0, 1,            3,            0,0,0,0,1, 1));
        tbl.push_back(mk(0,1,5, 0,            0,     0,0, 1,            3,            0,0,0,0,0, 1));
        tbl.push_back(mk(0,1,6, 0,            0,     0,0, 1,            3,            0,0,0,0,0, 3));
        // MULT 2*4 in flight, MTHI waits, then writes; MTLO writes LO
        tbl.push_back(mk(0,1,1, 2,            4,     0,0, 1,            3,            1,1,0,0,0, 0));
        tbl.push_back(mk(0,1,7, 32'hDEADBEEF, 0,     0,1, 1,            3,            0,0,0,1,1, 0));
        tbl.push_back(mk(0,1,7, 32'hDEADBEEF, 0,     0,1, 1,            3,            0,0,0,1,1, 0));
        tbl.push_back(mk(0,1,7, 32'hDEADBEEF, 0,     0,0, 0,            8,            0,0,0,1,1, 0));
        tbl.push_back(mk(0,1,7, 32'hDEADBEEF, 0,     0,0, 0,            8,            0,0,1,1,0, 0));
        tbl.push_back(mk(0,1,5, 0,            0,     0,0, 32'hDEADBEEF, 8,            0,0,0,0,0, 32'hDEADBEEF));
        tbl.push_back(mk(0,1,8, 32'h12345678, 0,     0,0, 32'hDEADBEEF, 8,            0,0,1,0,0, 0));
        // unused opcode 12 in IDLE: nothing happens
        tbl.push_back(mk(0,1,12,5,            6,     0,0, 32'hDEADBEEF, 32'h12345678, 0,0,0,0,0, 0));
        // DIVU 100/7; op 15 and NONE never stall; a second DIVU waits
        tbl.push_back(mk(0,1,4, 100,          7,     0,0, 32'hDEADBEEF, 32'h12345678, 1,2,0,0,0, 0));
        tbl.push_back(mk(0,1,15,0,            0,     0,1, 32'hDEADBEEF, 32'h12345678, 0,0,0,0,0, 0));
        tbl.push_back(mk(0,1,0, 0,            0,     0,1, 32'hDEADBEEF, 32'h12345678, 0,0,0,0,0, 0));
        tbl.push_back(mk(0,1,4, 100,          7,     0,0, 2,            14,           0,2,0,0,1, 0));
        tbl.push_back(mk(0,1,4, 100,          7,     0,0, 2,            14,           1,2,0,0,0, 0));
        // Busy never rises: ISSUED falls straight back to IDLE
        tbl.push_back(mk(0,0,0, 0,            0,     0,0, 2,            14,           0,0,0,0,0, 0));
        tbl.push_back(mk(0,1,6, 0,            0,     0,0, 2,            14,           0,0,0,0,0, 14));
        // flushed MULT: no start; invalid MULT: no start
        tbl.push_back(mk(0,1,1, 9,            9,     1,0, 2,            14,           0,1,0,0,0, 0));
        tbl.push_back(mk(0,1,6, 0,            0,     0,0, 2,            14,           0,0,0,0,0, 14));
        tbl.push_back(mk(0,0,1, 9,            9,     0,0, 2,            14,           0,1,0,0,0, 0));
        // MULT in flight, flushed MFLO: no stall, HI/LO still complete
        tbl.push_back(mk(0,1,1, 6,            7,     0,0, 2,            14,           1,1,0,0,0, 0));
        tbl.push_back(mk(0,1,6, 0,            0,     1,1, 2,            14,           0,0,0,0,0, 14));
        tbl.push_back(mk(0,1,6, 0,            0,     1,1, 2,            14,           0,0,0,0,0, 14));
        tbl.push_back(mk(0,1,6, 0,            0,     1,0, 0,            42,           0,0,0,0,0, 42));
        tbl.push_back(mk(0,1,6, 0,            0,     0,0, 0,            42,           0,0,0,0,0, 42));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a DIV WAIT, then an immediate new MULTU.
        apply(mk(0,1,3, 50,0,0,0, 0,42, 1,3,0,0,0, 0), "rst_div_start");
        apply(mk(0,1,5, 0, 0,0,1, 0,42, 0,0,0,0,1, 0), "rst_issued");
        apply(mk(0,1,5, 0, 0,0,1, 0,42, 0,0,0,0,1, 0), "rst_wait");
        apply(mk(1,1,5, 0, 0,0,1, 0,42, 0,0,0,0,0, 0), "rst_assert");
        apply(mk(0,1,2, 3, 3,0,0, 0,0,  1,0,0,0,0, 0), "rst_new_multu");
        apply(mk(0,0,0, 0, 0,0,0, 0,9,  0,0,0,0,0, 0), "rst_issued_idle");
        apply(mk(0,1,6, 0, 0,0,0, 0,9,  0,0,0,0,0, 9), "rst_mflo");

`ifdef MD_WDOG_EN
        // Watchdog: Busy held high; limit 4 WAIT cycles.
        drive(mk(1,0,0, 0,0,0,0, 0,0, 0,0,0,0,0, 0));
        drive(mk(0,1,2, 1,1,0,0, 0,0, 0,0,0,0,0, 0));
        chk("wd.start", {31'd0, wd_start}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            drive(mk(0,1,6, 0,0,0,1, 0,0, 0,0,0,0,0, 0));
            chk($sformatf("wd.stall%0d", i),   {31'd0, wd_stall},   32'd1);
            chk($sformatf("wd.timeout%0d", i), {31'd0, wd_timeout}, 32'd0);
        end
        drive(mk(0,1,6, 0,0,0,1, 0,0, 0,0,0,0,0, 0));
        chk("wd.released",    {31'd0, wd_stall},   32'd0);
        chk("wd.timeout_set", {31'd0, wd_timeout}, 32'd1);
        drive(mk(0,0,0, 0,0,0,1, 0,0, 0,0,0,0,0, 0));
        chk("wd.timeout_held", {31'd0, wd_timeout}, 32'd1);
        drive(mk(1,0,0, 0,0,0,0, 0,0, 0,0,0,0,0, 0));
        drive(mk(0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0, 0));
        chk("wd.timeout_cleared", {31'd0, wd_timeout}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
